// File: rtl/waveform_seq_pkg.sv
// +----------------------------------------------------------------------+
// | waveform_seq_pkg                                                     |
// | Shared types for the waveform segment sequencer. WAVESEQ_SWEEP_EN    |
// | adds a per-entry signed step field to the entry struct.              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package waveform_seq_pkg;

  // Duration field in the entry struct is fixed wide; the table keeps DUR_W bits.
  localparam int DUR_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [2:0] SIN    = 3'd0;
  localparam logic [2:0] NOISE  = 3'd1;
  localparam logic [2:0] TRI    = 3'd2;
  localparam logic [2:0] SQUARE = 3'd3;
  localparam logic [2:0] SAW    = 3'd4;
  localparam logic [2:0] RAMP   = 3'd5;

  typedef struct packed {
    logic [2:0]           wave;
    logic [31:0]          adder;
    logic [DUR_MAX_W-1:0] dur;
    logic                 last;
`ifdef WAVESEQ_SWEEP_EN
    logic [31:0]          step;
`endif
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/seq_table.sv
// +----------------------------------------------------------------------+
// | seq_table                                                            |
// | Segment entry storage: one synchronous write, one async read port.   |
// | Step storage exists only when WAVESEQ_SWEEP_EN is defined.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_table
  import waveform_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DUR_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  entry_t                   wr_entry,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output entry_t                   rd_entry
);

  logic [2:0]       wave_mem  [DEPTH];
  logic [31:0]      adder_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem   [DEPTH];
  logic [DEPTH-1:0] last_mem;
`ifdef WAVESEQ_SWEEP_EN
  logic [31:0]      step_mem  [DEPTH];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        wave_mem[i]  <= '0;
        adder_mem[i] <= '0;
        dur_mem[i]   <= '0;
`ifdef WAVESEQ_SWEEP_EN
        step_mem[i]  <= '0;
`endif
      end
      last_mem <= '0;
    end else if (wr_en) begin
      wave_mem[wr_addr]  <= wr_entry.wave;
      adder_mem[wr_addr] <= wr_entry.adder;
      dur_mem[wr_addr]   <= wr_entry.dur[DUR_W-1:0];
      last_mem[wr_addr]  <= wr_entry.last;
`ifdef WAVESEQ_SWEEP_EN
      step_mem[wr_addr]  <= wr_entry.step;
`endif
    end
  end

  always_comb begin
    rd_entry       = '0;
    rd_entry.wave  = wave_mem[rd_addr];
    rd_entry.adder = adder_mem[rd_addr];
    rd_entry.dur   = 32'(dur_mem[rd_addr]);
    rd_entry.last  = last_mem[rd_addr];
`ifdef WAVESEQ_SWEEP_EN
    rd_entry.step  = step_mem[rd_addr];
`endif
  end

  // The writer zero-extends the duration, so the upper struct bits carry nothing.
  if (DUR_W < DUR_MAX_W) begin : g_dur_hi
    logic unused_dur_hi;
    assign unused_dur_hi = ^wr_entry.dur[DUR_MAX_W-1:DUR_W];
  end

endmodule

`default_nettype wire

// File: rtl/waveform_sequencer.sv
// +----------------------------------------------------------------------+
// | waveform_sequencer                                                   |
// | Plays a table of {wave, adder, duration} segments into a signal      |
// | generator; WAVESEQ_SWEEP_EN adds a per-cycle adder sweep.            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module waveform_sequencer
  import waveform_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DUR_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [2:0]               cfg_wave,
  input  logic [31:0]              cfg_adder,
  input  logic [DUR_W-1:0]         cfg_dur,
  input  logic                     cfg_last,
`ifdef WAVESEQ_SWEEP_EN
  input  logic [31:0]              cfg_step,
`endif
  input  logic                     start,
  input  logic                     pause,
  input  logic                     stop,
  input  logic                     loop_en,
  output logic [2:0]               signalNumber,
  output logic [31:0]              adder,
  output logic [$clog2(DEPTH)-1:0] seg_index,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);

  state_t           state;
  logic [DUR_W-1:0] remaining;
  logic             cur_last;
  logic [31:0]      run_adder;
`ifdef WAVESEQ_SWEEP_EN
  logic [31:0]      cur_step;
`endif

  entry_t           wr_entry;
  entry_t           rd_entry;
  logic [AW-1:0]    rd_addr;
  logic [DUR_W-1:0] load_dur;
  logic             load_last;

  always_comb begin
    wr_entry       = '0;
    wr_entry.wave  = cfg_wave;
    wr_entry.adder = cfg_adder;
    wr_entry.dur   = 32'(cfg_dur);
    wr_entry.last  = cfg_last;
`ifdef WAVESEQ_SWEEP_EN
    wr_entry.step  = cfg_step;
`endif
  end

  seq_table #(
    .DEPTH (DEPTH),
    .DUR_W (DUR_W)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (cfg_we),
    .wr_addr  (cfg_addr),
    .wr_entry (wr_entry),
    .rd_addr  (rd_addr),
    .rd_entry (rd_entry)
  );

  // The read port always presents the entry the next load would take.
  assign rd_addr   = (state == IDLE || cur_last) ? '0 : seg_index + AW'(1);
  assign load_dur  = (rd_entry.dur == 32'd0) ? DUR_W'(1) : rd_entry.dur[DUR_W-1:0];
  assign load_last = rd_entry.last || (rd_addr == AW'(DEPTH - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (reset) begin
      state        <= IDLE;
      signalNumber <= '0;
      adder        <= '0;
      seg_index    <= '0;
      remaining    <= '0;
      cur_last     <= 1'b0;
      run_adder    <= '0;
`ifdef WAVESEQ_SWEEP_EN
      cur_step     <= '0;
`endif
    end else if (stop) begin
      state <= IDLE;
      adder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state        <= RUN;
            signalNumber <= rd_entry.wave;
            adder        <= rd_entry.adder;
            run_adder    <= rd_entry.adder;
            remaining    <= load_dur;
            seg_index    <= rd_addr;
            cur_last     <= load_last;
`ifdef WAVESEQ_SWEEP_EN
            cur_step     <= rd_entry.step;
`endif
          end
        end
        // Resume performs the advance owed for the last RUN cycle before the pause,
        // so a paused segment still totals its programmed RUN cycles.
        RUN, PAUSE: begin
          if (pause) begin
            state <= PAUSE;
            adder <= '0;
          end else if (remaining == DUR_W'(1)) begin
            if (!cur_last || loop_en) begin
              state        <= RUN;
              signalNumber <= rd_entry.wave;
              adder        <= rd_entry.adder;
              run_adder    <= rd_entry.adder;
              remaining    <= load_dur;
              seg_index    <= rd_addr;
              cur_last     <= load_last;
`ifdef WAVESEQ_SWEEP_EN
              cur_step     <= rd_entry.step;
`endif
            end else begin
              state <= IDLE;
              adder <= '0;
              done  <= 1'b1;
            end
          end else begin
            state     <= RUN;
            remaining <= remaining - DUR_W'(1);
`ifdef WAVESEQ_SWEEP_EN
            run_adder <= run_adder + cur_step;
            adder     <= run_adder + cur_step;
`else
            adder     <= run_adder;
`endif
          end
        end
        default: begin
          state <= IDLE;
          adder <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_waveform_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_waveform_sequencer                                                |
// | Directed bench for waveform_sequencer (DEPTH=8, DUR_W=24); the sweep |
// | scenario is included when WAVESEQ_SWEEP_EN is defined.               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_waveform_sequencer;
  import waveform_seq_pkg::*;

  logic        clk;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [2:0]  cfg_wave;
  logic [31:0] cfg_adder;
  logic [23:0] cfg_dur;
  logic        cfg_last;
`ifdef WAVESEQ_SWEEP_EN
  logic [31:0] cfg_step;
`endif
  logic        start;
  logic        pause;
  logic        stop;
  logic        loop_en;
  logic [2:0]  signalNumber;
  logic [31:0] adder;
  logic [2:0]  seg_index;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  waveform_sequencer #(
    .DEPTH (8),
    .DUR_W (24)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wave     (cfg_wave),
    .cfg_adder    (cfg_adder),
    .cfg_dur      (cfg_dur),
    .cfg_last     (cfg_last),
`ifdef WAVESEQ_SWEEP_EN
    .cfg_step     (cfg_step),
`endif
    .start        (start),
    .pause        (pause),
    .stop         (stop),
    .loop_en      (loop_en),
    .signalNumber (signalNumber),
    .adder        (adder),
    .seg_index    (seg_index),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] s, input logic [31:0] a,
                           input logic [2:0] idx, input logic b, input logic d);
    chk({tag, ".signalNumber"}, 32'(signalNumber), 32'(s));
    chk({tag, ".adder"},        adder,             a);
    chk({tag, ".seg_index"},    32'(seg_index),    32'(idx));
    chk({tag, ".busy"},         32'(busy),         32'(b));
    chk({tag, ".done"},         32'(done),         32'(d));
  endtask

  task automatic wr(input int a, input logic [2:0] w, input logic [31:0] ad,
                    input logic [23:0] d, input logic l);
    cfg_addr  = 3'(a);
    cfg_wave  = w;
    cfg_adder = ad;
    cfg_dur   = d;
    cfg_last  = l;
    cfg_we    = 1'b1;
    tick();
    cfg_we    = 1'b0;
  endtask

  initial begin
    int exp_seg [9];
    exp_seg = '{0, 1, 2, 3, 4, 5, 5, 6, 7};

    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wave = '0; cfg_adder = '0;
    cfg_dur = '0; cfg_last = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
`ifdef WAVESEQ_SWEEP_EN
    cfg_step = '0;
`endif
    tick();
    tick();
    check_out("reset", 3'd0, 32'h0, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_out("idle", 3'd0, 32'h0, 3'd0, 1'b0, 1'b0);

    // Two-segment one-shot: 3 cycles SAW then 2 cycles SIN, then done.
    wr(0, SAW, 32'h0100_0000, 24'd3, 1'b0);
    wr(1, SIN, 32'h0200_0000, 24'd2, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check_out("once0a", SAW, 32'h0100_0000, 3'd0, 1'b1, 1'b0); tick();
    check_out("once0b", SAW, 32'h0100_0000, 3'd0, 1'b1, 1'b0); tick();
    check_out("once0c", SAW, 32'h0100_0000, 3'd0, 1'b1, 1'b0); tick();
    check_out("once1a", SIN, 32'h0200_0000, 3'd1, 1'b1, 1'b0); tick();
    check_out("once1b", SIN, 32'h0200_0000, 3'd1, 1'b1, 1'b0); tick();
    check_out("once_done", SIN, 32'h0, 3'd1, 1'b0, 1'b1); tick();
    check_out("once_after", SIN, 32'h0, 3'd1, 1'b0, 1'b0);

    // Looping 3,2,3,2 with no gaps, then stop mid-segment.
    loop_en = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) < 3) check_out("loop_saw", SAW, 32'h0100_0000, 3'd0, 1'b1, 1'b0);
      else             check_out("loop_sin", SIN, 32'h0200_0000, 3'd1, 1'b1, 1'b0);
      tick();
    end
    check_out("loop_third", SAW, 32'h0100_0000, 3'd0, 1'b1, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    check_out("stop", SAW, 32'h0, 3'd0, 1'b0, 1'b0); tick();
    check_out("stop_after", SAW, 32'h0, 3'd0, 1'b0, 1'b0);
    loop_en = 1'b0;

    // Pause for 4 cycles in a dur-5 segment; RUN cycles still total 5.
    wr(0, TRI, 32'h0000_1000, 24'd5, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check_out("prun0", TRI, 32'h0000_1000, 3'd0, 1'b1, 1'b0); tick();
    check_out("prun1", TRI, 32'h0000_1000, 3'd0, 1'b1, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("paused", TRI, 32'h0, 3'd0, 1'b1, 1'b0);
    end
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("presume", TRI, 32'h0000_1000, 3'd0, 1'b1, 1'b0);
    end
    tick();
    check_out("pdone", TRI, 32'h0, 3'd0, 1'b0, 1'b1);

    // No last flags: entry 7 ends it; dur 0 plays one cycle; codes 6/7 pass through.
    for (int i = 0; i < 8; i++)
      wr(i, 3'(i), 32'(16 * (i + 1)), (i == 3) ? 24'd0 : ((i == 5) ? 24'd2 : 24'd1), 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check_out("walk", 3'(exp_seg[i]), 32'(16 * (exp_seg[i] + 1)), 3'(exp_seg[i]), 1'b1, 1'b0);
      tick();
    end
    check_out("walk_done", 3'd7, 32'h0, 3'd7, 1'b0, 1'b1);

    // Rewrite entry 1 while entry 0 plays; a second start is ignored.
    wr(0, SQUARE, 32'h0000_AAAA, 24'd4, 1'b0);
    wr(1, NOISE,  32'h0000_5555, 24'd2, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check_out("rw0", SQUARE, 32'h0000_AAAA, 3'd0, 1'b1, 1'b0);
    cfg_addr = 3'd1; cfg_wave = RAMP; cfg_adder = 32'h0000_7777; cfg_dur = 24'd2; cfg_last = 1'b1;
    cfg_we = 1'b1; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    check_out("rw1", SQUARE, 32'h0000_AAAA, 3'd0, 1'b1, 1'b0); tick();
    check_out("rw2", SQUARE, 32'h0000_AAAA, 3'd0, 1'b1, 1'b0); tick();
    check_out("rw3", SQUARE, 32'h0000_AAAA, 3'd0, 1'b1, 1'b0); tick();
    check_out("rw_new1a", RAMP, 32'h0000_7777, 3'd1, 1'b1, 1'b0); tick();
    check_out("rw_new1b", RAMP, 32'h0000_7777, 3'd1, 1'b1, 1'b0); tick();
    check_out("rw_done", RAMP, 32'h0, 3'd1, 1'b0, 1'b1);

`ifdef WAVESEQ_SWEEP_EN
    // Sweep wraps modulo 2^32.
    cfg_step = 32'd1;
    wr(0, SIN, 32'hFFFF_FFFE, 24'd4, 1'b1);
    cfg_step = 32'd0;
    start = 1'b1; tick(); start = 1'b0;
    check_out("sweep0", SIN, 32'hFFFF_FFFE, 3'd0, 1'b1, 1'b0); tick();
    check_out("sweep1", SIN, 32'hFFFF_FFFF, 3'd0, 1'b1, 1'b0); tick();
    check_out("sweep2", SIN, 32'h0000_0000, 3'd0, 1'b1, 1'b0); tick();
    check_out("sweep3", SIN, 32'h0000_0001, 3'd0, 1'b1, 1'b0); tick();
    check_out("sweep_done", SIN, 32'h0, 3'd0, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/waveform_sequencer.md
# waveform_sequencer

Programmable segment sequencer that drives the `signalNumber`/`adder` controls of `signalGenerator`. It holds a small table of segments; each segment is a waveform code, a phase increment and a duration in clock cycles. On `start` it plays the segments in order, once or looping. It also provides pause/stop control, so host logic can schedule multi-tone or multi-shape bursts without cycle-accurate software writes.

## Interface
Parameters:
- `DEPTH`, 8 — number of table entries, power of two, ≥2; `AW = $clog2(DEPTH)`
- `DUR_W`, 24 — width of the segment duration field

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `cfg_we`  in  1  table write strobe
- `cfg_addr`  in  AW  entry index to write
- `cfg_wave`  in  3  waveform code for the entry
- `cfg_adder`  in  32  phase increment for the entry
- `cfg_dur`  in  DUR_W  segment length in cycles; 0 is treated as 1
- `cfg_last`  in  1  entry terminates the sequence
- `cfg_step`  in  32  per-cycle signed adder delta; present only with `WAVESEQ_SWEEP_EN`
- `start`  in  1  begin playback from entry 0
- `pause`  in  1  level; freeze playback while high
- `stop`  in  1  abort playback
- `loop_en`  in  1  after the last entry, restart at entry 0 instead of finishing
- `signalNumber`  out  3  waveform select to the generator
- `adder`  out  32  phase increment to the generator
- `seg_index`  out  AW  entry currently playing
- `busy`  out  1  state is RUN or PAUSE
- `done`  out  1  one-cycle pulse when a non-looping sequence completes

## Operation
- Reset value of every output is 0. Reset also sets state to IDLE and `remaining` to 0. Table contents are also cleared to 0.
- States:
  - IDLE: `adder`=0, so the generator phase is frozen. `signalNumber` holds its last value.
  - RUN: outputs track the current entry.
  - PAUSE: `adder`=0; the duration counter and `seg_index` are held.
- Entry load, which happens at start and at each segment boundary, performs all of the following:
  - `signalNumber` ← wave
  - `adder` ← adder field
  - `remaining` ← max(dur,1)
  - `seg_index` ← index
- Transitions, checked in this priority order:
  - `stop`: any state → IDLE, `adder`=0, no `done` pulse.
  - IDLE & `start`: load entry 0, go to RUN.
  - RUN & `pause`: go to PAUSE.
  - PAUSE & !`pause`: go to RUN and restore `adder` to the entry value (or to the swept value when sweep is enabled).
  - RUN & `remaining`==1 & entry is not last: load entry `seg_index`+1.
  - RUN & `remaining`==1 & entry is last & `loop_en`: load entry 0.
  - RUN & `remaining`==1 & entry is last & !`loop_en`: go to IDLE, `adder`=0, `done`=1 for one cycle.
  - RUN otherwise: `remaining` decrements by 1.
- An entry is last if its `cfg_last` is set or its index is `DEPTH-1`. The index never wraps past the table end.
- `start` while `busy` is ignored.
- `pause` and `start` sampled together in IDLE: load entry 0, then enter PAUSE on the next edge if `pause` is still high.
- Table writes are accepted in any state and take effect only when that entry is next loaded. A write to the playing entry does not alter the current outputs.
- Waveform codes 6 and 7 are stored and forwarded unchanged. The generator holds its previous output for these codes.
- `loop_en` is sampled at the last-entry boundary only.

## Timing
- `start` sampled at edge N → `busy`, `signalNumber` and `adder` are valid after edge N.
- A segment with duration D keeps its outputs for exactly D cycles, including the load cycle. Segment boundaries have no gap cycle.
- `done` asserts in the same cycle that `busy` falls.
- `stop` or `pause` sampled at edge N → `adder`=0 after edge N.
- A table write at edge N is visible to an entry load at edge N+1 or later. A same-edge write and load of the same entry uses the old data.

## Configuration
- `WAVESEQ_SWEEP_EN` defined:
  - Each entry also stores `cfg_step`.
  - In RUN, every cycle after the load cycle: `adder` ← `adder` + step, modulo 2^32.
  - During PAUSE the running swept value is retained internally and restored on resume.
- `WAVESEQ_SWEEP_EN` undefined:
  - The `cfg_step` port and the step storage are absent.
  - `adder` stays constant within a segment.

## Structure
- Package `waveform_seq_pkg`:
  - state enum (IDLE, RUN, PAUSE)
  - waveform code constants: SIN=0, NOISE=1, TRI=2, SQUARE=3, SAW=4, RAMP=5
  - entry struct: wave, adder, dur, last, and step (step only under the macro)
- Sub-module `seq_table`: register-array entry storage with one synchronous write port and one asynchronous read port, sized by `DEPTH` and `DUR_W`.

## Test plan
- Entry 0 = {SAW, 0x0100_0000, dur 3}; entry 1 = {SIN, 0x0200_0000, dur 2, last}; `start` → SAW/0x0100_0000 for 3 cycles, then SIN/0x0200_0000 for 2 cycles, then `done` pulses once and `adder`=0.
- Same table with `loop_en`=1 → pattern 3,2,3,2 with no gap cycles; `stop` mid-segment → `adder`=0 next cycle, `done` stays low.
- `pause` held for 4 cycles midway through a dur-5 segment → `adder`=0 for those 4 cycles, then the remaining cycles of the segment complete with the entry's `adder`; total RUN time still 5 cycles.
- No `cfg_last` set anywhere and `DEPTH`=8 → entry 7 terminates the sequence; `cfg_dur`=0 entry → held for exactly 1 cycle.
- Write entry 1 while entry 0 plays, and `start` while `busy` → entry 1 plays the new data; the second `start` has no effect.
- With `WAVESEQ_SWEEP_EN`: adder 0xFFFF_FFFE, step 1, dur 4 → `adder` sequence FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
